mux_tree_pipe: RTL and testbench

- Parametrised, pipelined N:1 data multiplexer built as a binary tree of 2:1 select levels, with one register stage per tree level.
- Successor to the fixed 16:1 single-bit combinational mux. Generalised in data width and input count.
- Adds valid/ready flow control with full backpressure, so it can sit between streaming blocks at high clock rates.

---
 rtl/mux_tree_pkg.sv | 28 ++
 rtl/mux_tree_stage.sv | 76 +++++++
 rtl/mux_tree_pipe.sv | 85 ++++++++
 tb/tb_mux_tree_pipe.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration helpers for the pipelined mux tree.
// Pure package: no logic, no latency.
package mux_tree_pkg;

  localparam int DATA_W_DEF = 8;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  // Lanes leaving level k.
  function automatic int lanes_at(input int num_in, input int k);
    return num_in >> (k + 1);
  endfunction

  // Lane offset of level k's input inside the flattened tree bus (level 0 at 0).
  function automatic int lane_off(input int num_in, input int k);
    return 2 * num_in - 2 * (num_in >> k);
  endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One tree level: 2:1 selects each lane pair into a valid/ready register slice, 1 cycle.
// Loads when empty or when downstream accepts; holds everything otherwise.
module mux_tree_stage
  import mux_tree_pkg::*;
#(
  parameter int LANES_IN = 2,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SELR_W   = 0,
  parameter int SEL_W    = 1,
  parameter int SEL_BIT  = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             up_vld_i,
  output logic                             up_rdy_o,
  input  logic [LANES_IN*DATA_W-1:0]       up_dat_i,
  input  logic [SEL_W-1:0]                 up_sel_i,
  output logic                             dn_vld_o,
  input  logic                             dn_rdy_i,
  output logic [(LANES_IN/2)*DATA_W-1:0]   dn_dat_o,
  output logic [SEL_W-1:0]                 dn_sel_o
);

  localparam int LANES_OUT = LANES_IN / 2;

  logic                        vld_q;
  logic [LANES_OUT*DATA_W-1:0] dat_d;
  logic [LANES_OUT*DATA_W-1:0] dat_q;
  logic                        unused_sel;

  // Select bit SEL_BIT high picks the odd lane of each pair.
  always_comb begin
    dat_d = '0;
    for (int j = 0; j < LANES_OUT; j++) begin
      dat_d[j*DATA_W +: DATA_W] = up_sel_i[SEL_BIT] ? up_dat_i[(2*j+1)*DATA_W +: DATA_W]
                                                    : up_dat_i[(2*j)*DATA_W +: DATA_W];
    end
  end

  assign up_rdy_o   = !vld_q || dn_rdy_i;
  assign dn_vld_o   = vld_q;
  assign dn_dat_o   = dat_q;
  assign unused_sel = ^up_sel_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (up_rdy_o) begin
      vld_q <= up_vld_i;
      if (up_vld_i) dat_q <= dat_d;
    end
  end

  // Only the select bits still needed downstream (or the whole select when echoed) are stored.
  if (SELR_W > 0) begin : g_selr
    logic [SELR_W-1:0] selr_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        selr_q <= '0;
      end else if (up_rdy_o && up_vld_i) begin
        selr_q <= up_sel_i[SEL_W-1 -: SELR_W];
      end
    end

    if (SELR_W < SEL_W) begin : g_pad
      assign dn_sel_o = {selr_q, {(SEL_W-SELR_W){1'b0}}};
    end else begin : g_full
      assign dn_sel_o = selr_q;
    end
  end else begin : g_nosel
    assign dn_sel_o = '0;
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN:1 mux tree, LEVELS cycles latency, full valid/ready backpressure with bubble collapse.
// MUX_TREE_PIPE_SEL_ECHO_EN adds out_sel, the select of the item on out_data.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NUM_IN = 16,
  localparam int SEL_W  = log2_ceil(NUM_IN),
  localparam int LEVELS = log2_ceil(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
  ,
  output logic [SEL_W-1:0]         out_sel
`endif
);

  if (!is_pow2(NUM_IN)) begin : g_bad_num_in
    $error("mux_tree_pipe: NUM_IN must be a power of two >= 2");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("mux_tree_pipe: DATA_W must be >= 1");
  end

  // All levels' lanes live in one flat bus: level k's input starts at lane_off(NUM_IN, k).
  logic [(2*NUM_IN-1)*DATA_W-1:0] tree_dat;
  logic [LEVELS:0]                lvl_vld;
  logic [LEVELS:0]                lvl_rdy;
  logic [SEL_W-1:0]               lvl_sel [0:LEVELS];

  assign tree_dat[NUM_IN*DATA_W-1:0] = in_data;
  assign lvl_vld[0]      = in_valid;
  assign lvl_sel[0]      = in_sel;
  assign lvl_rdy[LEVELS] = out_ready;
  assign in_ready        = lvl_rdy[0] && !rst;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int LANES_IN = NUM_IN >> k;
    localparam int OFF_IN   = lane_off(NUM_IN, k) * DATA_W;
    localparam int OFF_OUT  = lane_off(NUM_IN, k + 1) * DATA_W;
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
    localparam int SELR_W   = SEL_W;
`else
    localparam int SELR_W   = SEL_W - k - 1;
`endif

    mux_tree_stage #(
      .LANES_IN (LANES_IN),
      .DATA_W   (DATA_W),
      .SELR_W   (SELR_W),
      .SEL_W    (SEL_W),
      .SEL_BIT  (k)
    ) u_stage (
      .clk_i    (clk),
      .rst_i    (rst),
      .up_vld_i (lvl_vld[k]),
      .up_rdy_o (lvl_rdy[k]),
      .up_dat_i (tree_dat[OFF_IN +: LANES_IN*DATA_W]),
      .up_sel_i (lvl_sel[k]),
      .dn_vld_o (lvl_vld[k+1]),
      .dn_rdy_i (lvl_rdy[k+1]),
      .dn_dat_o (tree_dat[OFF_OUT +: lanes_at(NUM_IN, k)*DATA_W]),
      .dn_sel_o (lvl_sel[k+1])
    );
  end

  assign out_data  = tree_dat[(2*NUM_IN-2)*DATA_W +: DATA_W];
  assign out_valid = lvl_vld[LEVELS];

`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
  assign out_sel = lvl_sel[LEVELS];
`else
  logic unused_sel_tail;
  assign unused_sel_tail = ^lvl_sel[LEVELS];
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: 16x8 directed tests plus 2x8 and 64x32 random sweeps.
// Expected items are queued on input transfers and compared on output transfers.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dat;
    logic [7:0]  sel;
    int          cyc;
  } exp_t;

  exp_t qm[$], qa[$], qb[$];
  int   n_vec = 0, n_err = 0;
  bit   lat_on = 1'b0, sw_lat = 1'b0, sw_done = 1'b0;

  // main 16x8 instance
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data;
  logic [3:0]   in_sel;
  logic [7:0]   out_data;
  // sweep instances
  logic         s_rst;
  logic         a_vld, a_rdy, a_ovld, a_ordy, b_vld, b_rdy, b_ovld, b_ordy;
  logic [15:0]  a_dat;
  logic [0:0]   a_sel;
  logic [7:0]   a_odat;
  logic [2047:0] b_dat;
  logic [5:0]   b_sel;
  logic [31:0]  b_odat;
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
  logic [3:0]   out_sel;
  logic [0:0]   a_osel;
  logic [5:0]   b_osel;
`endif

  mux_tree_pipe #(.DATA_W(8), .NUM_IN(16)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
    , .out_sel(out_sel)
`endif
  );

  mux_tree_pipe #(.DATA_W(8), .NUM_IN(2)) u_dut_a (
    .clk(clk), .rst(s_rst), .in_data(a_dat), .in_sel(a_sel), .in_valid(a_vld),
    .in_ready(a_rdy), .out_data(a_odat), .out_valid(a_ovld), .out_ready(a_ordy)
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
    , .out_sel(a_osel)
`endif
  );

  mux_tree_pipe #(.DATA_W(32), .NUM_IN(64)) u_dut_b (
    .clk(clk), .rst(s_rst), .in_data(b_dat), .in_sel(b_sel), .in_valid(b_vld),
    .in_ready(b_rdy), .out_data(b_odat), .out_valid(b_ovld), .out_ready(b_ordy)
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
    , .out_sel(b_osel)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: pop on output transfer, then push on input transfer.
  exp_t em, ea, eb;
  always @(negedge clk) begin
    if (rst) begin
      qm.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (qm.size() == 0) chk("m_spurious", 64'(out_valid), 64'd0);
        else begin
          em = qm.pop_front();
          chk("m_dat", 64'(out_data), 64'(em.dat));
          if (lat_on) chk("m_lat", 64'(cyc - em.cyc), 64'd4);
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
          chk("m_sel", 64'(out_sel), 64'(em.sel));
`endif
        end
      end
      if (in_valid && in_ready)
        qm.push_back('{dat: 32'(in_data[in_sel*8 +: 8]), sel: 8'(in_sel), cyc: cyc});
    end
  end

  always @(negedge clk) begin
    if (s_rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_ovld && a_ordy) begin
        if (qa.size() == 0) chk("a_spurious", 64'(a_ovld), 64'd0);
        else begin
          ea = qa.pop_front();
          chk("a_dat", 64'(a_odat), 64'(ea.dat));
          if (sw_lat) chk("a_lat", 64'(cyc - ea.cyc), 64'd1);
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
          chk("a_sel", 64'(a_osel), 64'(ea.sel));
`endif
        end
      end
      if (b_ovld && b_ordy) begin
        if (qb.size() == 0) chk("b_spurious", 64'(b_ovld), 64'd0);
        else begin
          eb = qb.pop_front();
          chk("b_dat", 64'(b_odat), 64'(eb.dat));
          if (sw_lat) chk("b_lat", 64'(cyc - eb.cyc), 64'd6);
`ifdef MUX_TREE_PIPE_SEL_ECHO_EN
          chk("b_sel", 64'(b_osel), 64'(eb.sel));
`endif
        end
      end
      if (a_vld && a_rdy) qa.push_back('{dat: 32'(a_dat[a_sel*8 +: 8]), sel: 8'(a_sel), cyc: cyc});
      if (b_vld && b_rdy) qb.push_back('{dat: b_dat[b_sel*32 +: 32], sel: 8'(b_sel), cyc: cyc});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  // Parameter sweep: constant out_ready (latency checked), then random backpressure.
  initial begin
    s_rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0; a_ordy = 1'b1; b_ordy = 1'b1;
    a_sel = '0; b_sel = '0; a_dat = '0; b_dat = '0;
    repeat (3) step();
    @(negedge clk);
    chk("a_rst_ovld", 64'(a_ovld), 64'd0);
    chk("b_rst_odat", 64'(b_odat), 64'd0);
    step();
    s_rst = 1'b0;
    sw_lat = 1'b1;
    for (int t = 0; t < 600; t++) begin
      if (t == 200) sw_lat = 1'b0;
      a_dat = 16'($urandom);
      a_sel = 1'($urandom);
      a_vld = 1'($urandom);
      for (int i = 0; i < 64; i++) b_dat[i*32 +: 32] = $urandom;
      b_sel = 6'($urandom);
      b_vld = 1'($urandom);
      if (t >= 200) begin
        a_ordy = 1'($urandom);
        b_ordy = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    a_vld = 1'b0; b_vld = 1'b0; a_ordy = 1'b1; b_ordy = 1'b1;
    repeat (12) step();
    sw_done = 1'b1;
  end

  initial begin
    int ov_cnt, k2, sent, t;
    bit ir_all, saw_low;
    logic [7:0] got;

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(8'hA0 + i);
    step(); step();
    @(negedge clk);
    chk("rst_ovld", 64'(out_valid), 64'd0);
    chk("rst_odat", 64'(out_data), 64'd0);
    chk("rst_irdy", 64'(in_ready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("irdy_after_rst", 64'(in_ready), 64'd1);

    // single item, sel 11
    step();
    lat_on = 1'b1;
    in_sel = 4'd11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ov_cnt = 0; ir_all = 1'b1; got = '0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) begin ov_cnt++; got = out_data; end
      ir_all &= in_ready;
    end
    chk("t1_ovcnt", 64'(ov_cnt), 64'd1);
    chk("t1_dat", 64'(got), 64'hAB);
    chk("t1_irdy", 64'(ir_all), 64'd1);

    // streaming sel 0..15
    step();
    k2 = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          in_sel = 4'(i); in_valid = 1'b1;
          step();
        end
        in_valid = 1'b0;
      end
      begin
        repeat (24) begin
          @(negedge clk);
          if (out_valid) begin
            chk("t2_seq", 64'(out_data), 64'(8'hA0 + k2));
            k2++;
          end
        end
      end
    join
    chk("t2_cnt", 64'(k2), 64'd16);

    // backpressure mid-stream
    lat_on = 1'b0;
    sent = 0; t = 0; saw_low = 1'b0;
    while (sent < 8 && t < 100) begin
      out_ready = !(t >= 2 && t < 8);
      in_valid = 1'b1;
      in_sel = 4'((sent * 5 + 1) % 16);
      @(negedge clk);
      if (in_ready) sent++;
      else saw_low = 1'b1;
      step();
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t3_irdy_fell", 64'(saw_low), 64'd1);
    chk("t3_sent", 64'(sent), 64'd8);
    repeat (10) step();
    chk("t3_drained", 64'(qm.size()), 64'd0);

    // bubble collapse: two items held while stalled
    out_ready = 1'b0; in_sel = 4'd3; in_valid = 1'b1; ir_all = 1'b1;
    @(negedge clk); ir_all &= in_ready;
    step();
    in_valid = 1'b0;
    repeat (2) begin @(negedge clk); ir_all &= in_ready; step(); end
    in_sel = 4'd9; in_valid = 1'b1;
    @(negedge clk); ir_all &= in_ready;
    step();
    in_valid = 1'b0;
    repeat (7) begin @(negedge clk); ir_all &= in_ready; step(); end
    chk("t4_irdy", 64'(ir_all), 64'd1);
    @(negedge clk);
    chk("t4_hold_vld", 64'(out_valid), 64'd1);
    chk("t4_hold_dat", 64'(out_data), 64'hA3);
    step();
    out_ready = 1'b1;
    repeat (6) step();
    chk("t4_drained", 64'(qm.size()), 64'd0);

    // reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      in_sel = 4'(i + 4); in_valid = 1'b1;
      step();
    end
    rst = 1'b1; in_sel = 4'd7;
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_ovld", 64'(out_valid), 64'd0);
    chk("t5_odat", 64'(out_data), 64'd0);
    chk("t5_irdy", 64'(in_ready), 64'd1);
    ov_cnt = 0;
    repeat (8) begin @(negedge clk); if (out_valid) ov_cnt++; end
    chk("t5_stale", 64'(ov_cnt), 64'd0);

    // random traffic
    step();
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 4; j++) in_data[j*32 +: 32] = $urandom;
      in_sel = 4'($urandom);
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();

    wait (sw_done);
    chk("m_final_empty", 64'(qm.size()), 64'd0);
    chk("a_final_empty", 64'(qa.size()), 64'd0);
    chk("b_final_empty", 64'(qb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
